// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer control path: instruction field
// positions, timing-state indices and the 3-to-8 one-hot helper.
package mano_pkg;

    localparam int WORD_W  = 16;
    localparam int OPC_HI  = 14;
    localparam int OPC_LO  = 12;
    localparam int IND_BIT = 15;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    function automatic logic [7:0] onehot3to8(input logic [2:0] sel);
        return 8'd1 << sel;
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder, shared by the timing and opcode decode.
module decoder_3to8
    import mano_pkg::*;
(
    input  logic [2:0] sel,
    output logic [7:0] y
);

    assign y = onehot3to8(sel);

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter and instruction-decode stage: one-hot T0..T5 timing,
// instruction register, registered opcode decode D and indirect bit J.
module timing_sequencer #(
    parameter int WORD_W   = mano_pkg::WORD_W,
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WORD_W-1:0]   mem_data,
    input  logic                sc_clr,
    input  logic                halt,
    output logic [T_STATES-1:0] T,
    output logic [7:0]          D,
    output logic                J,
    output logic [WORD_W-1:0]   ir,
    output logic                running,
    output logic [15:0]         instr_count
);

    import mano_pkg::*;

    localparam logic [2:0] SC_LAST = 3'(T_STATES - 1);

    seq_state_e        state_q, state_d;
    logic [2:0]        sc_q, sc_d;
    logic              halt_pend_q, halt_pend_d;
    logic [15:0]       count_q, count_d;
    logic [WORD_W-1:0] ir_q;
    logic [7:0]        d_q;
    logic              j_q;
    logic              load_ir;

    logic [7:0]        t_full;
    logic [7:0]        d_next;
    logic              unused_t;

    decoder_3to8 u_t_dec (
        .sel (sc_q),
        .y   (t_full)
    );

    decoder_3to8 u_d_dec (
        .sel (mem_data[WORD_W-2:WORD_W-4]),
        .y   (d_next)
    );

    assign unused_t = ^t_full[7:T_STATES];

    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        halt_pend_d = halt_pend_q;
        count_d     = count_q;
        load_ir     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // halt arriving with start is dropped; sc_clr is meaningless here
                if (start) begin
                    state_d = ST_RUN;
                    sc_d    = T0;
                end
            end
            ST_RUN: begin
                load_ir = (sc_q == T1);
                // Boundary: honoured clear in T3..T5, or forced wrap out of the last state
                if ((sc_q >= T3 && sc_clr) || sc_q == SC_LAST) begin
                    count_d = count_q + 16'd1;
                    sc_d    = T0;
                    if (halt_pend_q || halt) begin
                        state_d     = ST_IDLE;
                        halt_pend_d = 1'b0;
                    end
                end else begin
                    sc_d = sc_q + 3'd1;
                    if (halt) begin
                        halt_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sc_q        <= T0;
            halt_pend_q <= 1'b0;
            count_q     <= 16'd0;
            ir_q        <= '0;
            d_q         <= 8'd0;
            j_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            halt_pend_q <= halt_pend_d;
            count_q     <= count_d;
            if (load_ir) begin
                ir_q <= mem_data;
                d_q  <= d_next;
                j_q  <= mem_data[WORD_W-1];
            end
        end
    end

    assign running     = (state_q == ST_RUN);
    assign T           = running ? t_full[T_STATES-1:0] : '0;
    assign D           = d_q;
    assign J           = j_q;
    assign ir          = ir_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: vector table plus hand-written
// sequences for async reset mid-instruction and instruction-counter wrap.
module tb_timing_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mem_data;
    logic        sc_clr;
    logic        halt;
    logic [5:0]  T;
    logic [7:0]  D;
    logic        J;
    logic [15:0] ir;
    logic        running;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    timing_sequencer #(.WORD_W(16), .T_STATES(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_data    (mem_data),
        .sc_clr      (sc_clr),
        .halt        (halt),
        .T           (T),
        .D           (D),
        .J           (J),
        .ir          (ir),
        .running     (running),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        clr;
        logic        halt;
        logic [15:0] mem;
        logic [5:0]  t;
        logic        run;
        logic [15:0] cnt;
        logic        dec;
        logic [15:0] ir;
        logic [7:0]  d;
        logic        j;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic c, input logic h, input logic [15:0] m);
        @(negedge clk);
        start    = s;
        sc_clr   = c;
        halt     = h;
        mem_data = m;
    endtask

    initial begin
        // Each row: inputs applied during a cycle, and outputs expected in that cycle.
        vecs[0]  = '{1, 0, 0, 16'h0000, 6'b000000, 0, 16'd0, 0, 16'h0000, 8'h00, 0};
        vecs[1]  = '{0, 0, 0, 16'h0000, 6'b000001, 1, 16'd0, 0, 16'h0000, 8'h00, 0};
        vecs[2]  = '{0, 0, 0, 16'hB123, 6'b000010, 1, 16'd0, 0, 16'h0000, 8'h00, 0};
        vecs[3]  = '{0, 1, 0, 16'h0000, 6'b000100, 1, 16'd0, 1, 16'hB123, 8'h08, 1};
        vecs[4]  = '{0, 0, 0, 16'h0000, 6'b001000, 1, 16'd0, 0, 16'h0000, 8'h00, 0};
        vecs[5]  = '{0, 0, 0, 16'h0000, 6'b010000, 1, 16'd0, 0, 16'h0000, 8'h00, 0};
        vecs[6]  = '{0, 0, 0, 16'h0000, 6'b100000, 1, 16'd0, 0, 16'h0000, 8'h00, 0};
        vecs[7]  = '{0, 0, 0, 16'h0000, 6'b000001, 1, 16'd1, 0, 16'h0000, 8'h00, 0};
        vecs[8]  = '{0, 0, 0, 16'h7005, 6'b000010, 1, 16'd1, 0, 16'h0000, 8'h00, 0};
        vecs[9]  = '{0, 1, 0, 16'h0000, 6'b000100, 1, 16'd1, 1, 16'h7005, 8'h80, 0};
        vecs[10] = '{0, 1, 0, 16'h0000, 6'b001000, 1, 16'd1, 0, 16'h0000, 8'h00, 0};
        vecs[11] = '{0, 0, 0, 16'h0000, 6'b000001, 1, 16'd2, 0, 16'h0000, 8'h00, 0};
        vecs[12] = '{0, 0, 1, 16'h0000, 6'b000010, 1, 16'd2, 0, 16'h0000, 8'h00, 0};
        vecs[13] = '{0, 0, 0, 16'h0000, 6'b000100, 1, 16'd2, 1, 16'h0000, 8'h01, 0};
        vecs[14] = '{0, 0, 0, 16'h0000, 6'b001000, 1, 16'd2, 0, 16'h0000, 8'h00, 0};
        vecs[15] = '{0, 1, 0, 16'h0000, 6'b010000, 1, 16'd2, 0, 16'h0000, 8'h00, 0};
        vecs[16] = '{0, 1, 0, 16'h0000, 6'b000000, 0, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[17] = '{0, 1, 1, 16'h0000, 6'b000000, 0, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[18] = '{1, 0, 1, 16'h0000, 6'b000000, 0, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[19] = '{0, 0, 0, 16'h0000, 6'b000001, 1, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[20] = '{1, 0, 0, 16'h8000, 6'b000010, 1, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[21] = '{0, 0, 0, 16'h0000, 6'b000100, 1, 16'd3, 1, 16'h8000, 8'h01, 1};
        vecs[22] = '{0, 0, 0, 16'h0000, 6'b001000, 1, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[23] = '{0, 0, 0, 16'h0000, 6'b010000, 1, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[24] = '{0, 0, 1, 16'h0000, 6'b100000, 1, 16'd3, 0, 16'h0000, 8'h00, 0};
        vecs[25] = '{0, 0, 0, 16'h0000, 6'b000000, 0, 16'd4, 0, 16'h0000, 8'h00, 0};

        rst = 1'b1; start = 1'b0; sc_clr = 1'b0; halt = 1'b0; mem_data = 16'h0000;
        #2;
        chk("reset_T", 32'(T), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        chk("reset_ir", 32'(ir), 32'd0);
        chk("reset_D", 32'(D), 32'd0);
        chk("reset_J", 32'(J), 32'd0);
        #5 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].start, vecs[i].clr, vecs[i].halt, vecs[i].mem);
            #1;
            chk($sformatf("vec%0d_T", i), 32'(T), 32'(vecs[i].t));
            chk($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].run));
            chk($sformatf("vec%0d_count", i), 32'(instr_count), 32'(vecs[i].cnt));
            if (vecs[i].dec) begin
                chk($sformatf("vec%0d_ir", i), 32'(ir), 32'(vecs[i].ir));
                chk($sformatf("vec%0d_D", i), 32'(D), 32'(vecs[i].d));
                chk($sformatf("vec%0d_J", i), 32'(J), 32'(vecs[i].j));
            end
        end

        // Fifth instruction, then async reset in the middle of T3 of the sixth.
        cyc(1, 0, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000); #1 chk("r_T0", 32'(T), 32'b000001);
        cyc(0, 0, 0, 16'h1234);
        cyc(0, 0, 0, 16'h0000);
        cyc(0, 1, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000); #1 chk("r_count5", 32'(instr_count), 32'd5);
        cyc(0, 0, 0, 16'h5A5A);
        cyc(0, 0, 0, 16'h0000); #1 chk("r_ir", 32'(ir), 32'h5A5A);
        cyc(0, 0, 0, 16'h0000); #1 chk("r_T3", 32'(T), 32'b001000);
        #1 rst = 1'b1;
        #1;
        chk("arst_T", 32'(T), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_count", 32'(instr_count), 32'd0);
        chk("arst_ir", 32'(ir), 32'd0);
        chk("arst_D", 32'(D), 32'd0);
        chk("arst_J", 32'(J), 32'd0);
        #1 rst = 1'b0;
        cyc(1, 0, 0, 16'h0000); #1 chk("restart_idle_T", 32'(T), 32'd0);
        cyc(0, 0, 0, 16'h0000); #1 chk("restart_T0", 32'(T), 32'b000001);
        chk("restart_running", 32'(running), 32'd1);
        cyc(0, 0, 1, 16'h0000);
        cyc(0, 0, 0, 16'h0000);
        cyc(0, 1, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000); #1 chk("halt_idle_running", 32'(running), 32'd0);
        chk("halt_idle_count", 32'(instr_count), 32'd1);

        // Counter wrap: preload 16'hFFFF while idle, then complete one instruction.
        force dut.count_q = 16'hFFFF;
        #1 release dut.count_q;
        #1 chk("preload_count", 32'(instr_count), 32'hFFFF);
        cyc(1, 0, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000);
        cyc(0, 1, 0, 16'h0000);
        cyc(0, 0, 0, 16'h0000); #1;
        chk("wrap_count", 32'(instr_count), 32'd0);
        chk("wrap_running", 32'(running), 32'd1);
        chk("wrap_T0", 32'(T), 32'b000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
